// File: rtl/cpu_defs.sv
// Shared LoongArch pipeline definitions: exception codes, load-size encodings
// and the exception cause used by the writeback arbiter.
package cpu_defs;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;

  typedef enum logic [1:0] {
    RDRAM_WORD = 2'b00,
    RDRAM_BYTE = 2'b01,
    RDRAM_HALF = 2'b10,
    RDRAM_RSVD = 2'b11
  } rdram_num_e;

  typedef enum logic [2:0] {
    EXC_NONE,
    EXC_INT,
    EXC_ADEF,
    EXC_INE,
    EXC_SYS,
    EXC_BRK,
    EXC_ALE
  } exc_e;

endpackage

// File: rtl/wb_stage_if.sv
// MEM->WB pipeline register outputs as seen by the writeback stage.
interface wb_stage_if;

  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        wb_rf_we;
  logic [4:0]  wb_rd;
  logic [4:0]  wb_rj;
  logic [31:0] wb_alu_result;
  logic        wb_res_from_dram;
  logic [31:0] wb_dram_rdata;
  logic [31:0] wb_data_addr;
  logic [1:0]  wb_rdram_num;
  logic        wb_rdram_need_signed_extend;
  logic        wb_rdram_need_zero_extend;
  logic        wb_res_from_csr;
  logic        wb_res_from_cnt;
  logic [31:0] wb_res_of_cnt;
  logic        wb_res_is_rj;
  logic        wb_has_int;
  logic        wb_ex_adef;
  logic        wb_ex_ine;
  logic        wb_is_syscall;
  logic        wb_ex_brk;
  logic        wb_ex_ale;
  logic        wb_is_ertn;

  modport master (
    output wb_valid, wb_pc, wb_rf_we, wb_rd, wb_rj, wb_alu_result,
           wb_res_from_dram, wb_dram_rdata, wb_data_addr, wb_rdram_num,
           wb_rdram_need_signed_extend, wb_rdram_need_zero_extend,
           wb_res_from_csr, wb_res_from_cnt, wb_res_of_cnt, wb_res_is_rj,
           wb_has_int, wb_ex_adef, wb_ex_ine, wb_is_syscall, wb_ex_brk,
           wb_ex_ale, wb_is_ertn
  );

  modport slave (
    input  wb_valid, wb_pc, wb_rf_we, wb_rd, wb_rj, wb_alu_result,
           wb_res_from_dram, wb_dram_rdata, wb_data_addr, wb_rdram_num,
           wb_rdram_need_signed_extend, wb_rdram_need_zero_extend,
           wb_res_from_csr, wb_res_from_cnt, wb_res_of_cnt, wb_res_is_rj,
           wb_has_int, wb_ex_adef, wb_ex_ine, wb_is_syscall, wb_ex_brk,
           wb_ex_ale, wb_is_ertn
  );

endinterface

// File: rtl/wb_load_align.sv
// Load data extraction: picks the addressed byte/half out of the raw word
// and sign- or zero-extends it to 32 bits.
module wb_load_align
  import cpu_defs::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [1:0]  num,
  input  logic        sign_ext,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    byte_v = rdata[{off, 3'b000} +: 8];
    // Halfword loads are already known to be aligned, so only off[1] matters.
    half_v = off[1] ? rdata[31:16] : rdata[15:0];
    data   = rdata;
    case (rdram_num_e'(num))
      RDRAM_BYTE: data = {{24{sign_ext & byte_v[7]}}, byte_v};
      RDRAM_HALF: data = {{16{sign_ext & half_v[15]}}, half_v};
      default:    data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback/commit stage: final GPR write, exception/ertn arbitration into a
// single flush, debug trace, and the stable / retired-instruction counters.
module wb_stage
  import cpu_defs::*;
#(
  parameter int CNT_W = 64,
  parameter int RET_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  wb_stage_if.slave        bus,
  input  logic [31:0]      csr_rdata,
  output logic             wb_ex,
  output logic [5:0]       wb_ecode,
  output logic [8:0]       wb_esubcode,
  output logic             wb_badv_we,
  output logic [31:0]      wb_badv,
  output logic             flush,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic [CNT_W-1:0] cnt_value,
  output logic [RET_W-1:0] retired,
  output logic [31:0]      debug_wb_pc,
  output logic [3:0]       debug_wb_rf_we,
  output logic [4:0]       debug_wb_rf_wnum,
  output logic [31:0]      debug_wb_rf_wdata
);

  logic             commit;
  logic             any_ex;
  logic             retire;
  exc_e             cause;
  logic [31:0]      load_data;
  logic [31:0]      result;
  logic [4:0]       waddr;
  logic [CNT_W-1:0] cnt_q;
  logic [RET_W-1:0] ret_q;

  // Zero extension is simply the absence of sign extension.
  logic unused_zero_ext;
  assign unused_zero_ext = bus.wb_rdram_need_zero_extend;

  assign commit = bus.wb_valid;

  // Fixed-priority exception arbiter: the first flag set wins.
  always_comb begin
    cause = EXC_NONE;
    if      (bus.wb_has_int)    cause = EXC_INT;
    else if (bus.wb_ex_adef)    cause = EXC_ADEF;
    else if (bus.wb_ex_ine)     cause = EXC_INE;
    else if (bus.wb_is_syscall) cause = EXC_SYS;
    else if (bus.wb_ex_brk)     cause = EXC_BRK;
    else if (bus.wb_ex_ale)     cause = EXC_ALE;
  end

  assign any_ex      = (cause != EXC_NONE);
  assign wb_ex       = commit & any_ex;
  assign retire      = commit & ~any_ex;
  assign flush       = wb_ex | (retire & bus.wb_is_ertn);
  assign wb_esubcode = '0;

  always_comb begin
    wb_ecode   = '0;
    wb_badv_we = 1'b0;
    wb_badv    = '0;
    if (commit) begin
      case (cause)
        EXC_INT:  wb_ecode = ECODE_INT;
        EXC_ADEF: begin
          wb_ecode   = ECODE_ADEF;
          wb_badv_we = 1'b1;
          wb_badv    = bus.wb_pc;
        end
        EXC_INE:  wb_ecode = ECODE_INE;
        EXC_SYS:  wb_ecode = ECODE_SYS;
        EXC_BRK:  wb_ecode = ECODE_BRK;
        EXC_ALE:  begin
          wb_ecode   = ECODE_ALE;
          wb_badv_we = 1'b1;
          wb_badv    = bus.wb_data_addr;
        end
        default:  wb_ecode = '0;
      endcase
    end
  end

  wb_load_align u_load_align (
    .rdata    (bus.wb_dram_rdata),
    .off      (bus.wb_data_addr[1:0]),
    .num      (bus.wb_rdram_num),
    .sign_ext (bus.wb_rdram_need_signed_extend),
    .data     (load_data)
  );

  always_comb begin
    result = bus.wb_alu_result;
    if      (bus.wb_res_from_dram) result = load_data;
    else if (bus.wb_res_from_csr)  result = csr_rdata;
    else if (bus.wb_res_from_cnt)  result = bus.wb_res_of_cnt;
  end

  assign waddr    = bus.wb_res_is_rj ? bus.wb_rj : bus.wb_rd;
  assign rf_we    = retire & bus.wb_rf_we & (waddr != 5'd0);
  assign rf_waddr = commit ? waddr  : '0;
  assign rf_wdata = commit ? result : '0;

  assign debug_wb_pc       = commit ? bus.wb_pc : '0;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ret_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (retire) ret_q <= ret_q + RET_W'(1);
    end
  end

  assign cnt_value = cnt_q;
  assign retired   = ret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: scoreboard of expected commit outputs plus
// a bench-side retired-instruction model and direct counter checks.
`define SB_CHECK(NAME) \
  begin \
    obs_t got_v, want_v; \
    got_v  = sample(); \
    want_v = sb.pop_front(); \
    n_chk++; \
    if (got_v !== want_v) begin \
      n_fail++; \
      $display("FAIL %s: got %h expected %h", NAME, got_v, want_v); \
    end \
  end

module tb_wb_stage;
  import cpu_defs::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_stage_if bus ();
  logic [31:0] csr_rdata;

  logic        wb_ex, wb_badv_we, flush, rf_we;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_badv, rf_wdata, debug_wb_pc, debug_wb_rf_wdata;
  logic [4:0]  rf_waddr, debug_wb_rf_wnum;
  logic [3:0]  debug_wb_rf_we;
  logic [63:0] cnt_value;
  logic [31:0] retired;

  wb_stage dut (
    .clk               (clk),
    .rst               (rst),
    .bus               (bus),
    .csr_rdata         (csr_rdata),
    .wb_ex             (wb_ex),
    .wb_ecode          (wb_ecode),
    .wb_esubcode       (wb_esubcode),
    .wb_badv_we        (wb_badv_we),
    .wb_badv           (wb_badv),
    .flush             (flush),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .cnt_value         (cnt_value),
    .retired           (retired),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  typedef struct packed {
    logic        ex;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic        badv_we;
    logic [31:0] badv;
    logic        flush;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] dpc;
    logic [3:0]  dwe;
    logic [4:0]  dwnum;
    logic [31:0] dwdata;
  } obs_t;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rd;
    logic [4:0]  rj;
    logic [31:0] alu;
    logic        from_dram;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [1:0]  num;
    logic        sext;
    logic        zext;
    logic        from_csr;
    logic [31:0] csr;
    logic        from_cnt;
    logic [31:0] res_of_cnt;
    logic        is_rj;
    logic        irq;
    logic        adef;
    logic        ine;
    logic        sys;
    logic        brk;
    logic        ale;
    logic        ertn;
  } stim_t;

  obs_t        sb[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] exp_ret;
  bit          pend;

  function automatic stim_t idle();
    stim_t s;
    s = '{valid: 1'b0, pc: '0, rf_we: 1'b0, rd: '0, rj: '0, alu: '0,
          from_dram: 1'b0, rdata: '0, addr: '0, num: '0, sext: 1'b0,
          zext: 1'b0, from_csr: 1'b0, csr: '0, from_cnt: 1'b0,
          res_of_cnt: '0, is_rj: 1'b0, irq: 1'b0, adef: 1'b0, ine: 1'b0,
          sys: 1'b0, brk: 1'b0, ale: 1'b0, ertn: 1'b0};
    return s;
  endfunction

  function automatic obs_t mk_exp(input logic ex, input logic [5:0] ecode,
                                  input logic bwe, input logic [31:0] badv,
                                  input logic fl, input logic we,
                                  input logic [4:0] wa, input logic [31:0] wd,
                                  input logic [31:0] pc);
    obs_t o;
    o.ex = ex;  o.ecode = ecode;  o.esub = '0;  o.badv_we = bwe;  o.badv = badv;
    o.flush = fl;  o.rf_we = we;  o.waddr = wa;  o.wdata = wd;  o.dpc = pc;
    o.dwe = {4{we}};  o.dwnum = wa;  o.dwdata = wd;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.ex = wb_ex;  o.ecode = wb_ecode;  o.esub = wb_esubcode;
    o.badv_we = wb_badv_we;  o.badv = wb_badv;  o.flush = flush;
    o.rf_we = rf_we;  o.waddr = rf_waddr;  o.wdata = rf_wdata;
    o.dpc = debug_wb_pc;  o.dwe = debug_wb_rf_we;
    o.dwnum = debug_wb_rf_wnum;  o.dwdata = debug_wb_rf_wdata;
    return o;
  endfunction

  task automatic apply(input stim_t s);
    bus.wb_valid                    = s.valid;
    bus.wb_pc                       = s.pc;
    bus.wb_rf_we                    = s.rf_we;
    bus.wb_rd                       = s.rd;
    bus.wb_rj                       = s.rj;
    bus.wb_alu_result               = s.alu;
    bus.wb_res_from_dram            = s.from_dram;
    bus.wb_dram_rdata               = s.rdata;
    bus.wb_data_addr                = s.addr;
    bus.wb_rdram_num                = s.num;
    bus.wb_rdram_need_signed_extend = s.sext;
    bus.wb_rdram_need_zero_extend   = s.zext;
    bus.wb_res_from_csr             = s.from_csr;
    csr_rdata                       = s.csr;
    bus.wb_res_from_cnt             = s.from_cnt;
    bus.wb_res_of_cnt               = s.res_of_cnt;
    bus.wb_res_is_rj                = s.is_rj;
    bus.wb_has_int                  = s.irq;
    bus.wb_ex_adef                  = s.adef;
    bus.wb_ex_ine                   = s.ine;
    bus.wb_is_syscall               = s.sys;
    bus.wb_ex_brk                   = s.brk;
    bus.wb_ex_ale                   = s.ale;
    bus.wb_is_ertn                  = s.ertn;
  endtask

  // Drive one cycle's inputs at the falling edge; the rising edge just passed
  // retired whatever was driven in the previous cycle.
  task automatic drive(input stim_t s, input bit counts);
    @(negedge clk);
    if (pend) exp_ret++;
    pend = counts;
    apply(s);
  endtask

  task automatic check_retired(input string name);
    n_chk++;
    if (retired !== exp_ret) begin
      n_fail++;
      $display("FAIL %s: retired got %h expected %h", name, retired, exp_ret);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    apply(idle());
    pend = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_ret = '0;
    sb.push_back(mk_exp(0, 6'h00, 0, '0, 0, 0, 5'd0, '0, '0));
    #1;
    `SB_CHECK("reset_idle")
    n_chk++;
    if (cnt_value !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %h expected %h", cnt_value, 64'd0);
    end
    check_retired("reset_retired");
    repeat (10) @(negedge clk);
    n_chk++;
    if (cnt_value !== 64'd10) begin
      n_fail++;
      $display("FAIL cnt_after_10: got %0d expected 10", cnt_value);
    end
  endtask

  task automatic test_load();
    stim_t s;
    s = idle();
    s.valid = 1'b1;  s.pc = 32'h1C00_0000;  s.rf_we = 1'b1;  s.rd = 5'd5;
    s.from_dram = 1'b1;  s.rdata = 32'h80FF_7F01;  s.addr = 32'h0000_1003;
    s.num = RDRAM_BYTE;  s.sext = 1'b1;  s.alu = 32'hDEAD_BEEF;
    drive(s, 1);
    sb.push_back(mk_exp(0, 6'h00, 0, '0, 0, 1, 5'd5, 32'hFFFF_FF80, s.pc));
    #1;
    `SB_CHECK("ld_b_sext_off3")

    s.sext = 1'b0;  s.zext = 1'b1;
    drive(s, 1);
    sb.push_back(mk_exp(0, 6'h00, 0, '0, 0, 1, 5'd5, 32'h0000_0080, s.pc));
    #1;
    `SB_CHECK("ld_b_zext_off3")

    s.sext = 1'b1;  s.zext = 1'b1;
    drive(s, 1);
    sb.push_back(mk_exp(0, 6'h00, 0, '0, 0, 1, 5'd5, 32'hFFFF_FF80, s.pc));
    #1;
    `SB_CHECK("ld_b_both_ext_sign_wins")

    s.zext = 1'b0;  s.addr = 32'h0000_1001;
    drive(s, 1);
    sb.push_back(mk_exp(0, 6'h00, 0, '0, 0, 1, 5'd5, 32'h0000_007F, s.pc));
    #1;
    `SB_CHECK("ld_b_sext_off1")

    s.num = RDRAM_HALF;  s.rdata = 32'h8001_1234;  s.addr = 32'h0000_1002;
    drive(s, 1);
    sb.push_back(mk_exp(0, 6'h00, 0, '0, 0, 1, 5'd5, 32'hFFFF_8001, s.pc));
    #1;
    `SB_CHECK("ld_h_sext_off2")

    s.sext = 1'b0;  s.zext = 1'b1;  s.addr = 32'h0000_1000;  s.rdata = 32'h8001_9234;
    drive(s, 1);
    sb.push_back(mk_exp(0, 6'h00, 0, '0, 0, 1, 5'd5, 32'h0000_9234, s.pc));
    #1;
    `SB_CHECK("ld_h_zext_off0")

    s.num = RDRAM_WORD;  s.rd = 5'd0;  s.rdata = 32'hCAFE_F00D;
    drive(s, 1);
    sb.push_back(mk_exp(0, 6'h00, 0, '0, 0, 0, 5'd0, 32'hCAFE_F00D, s.pc));
    #1;
    `SB_CHECK("ld_w_rd0")

    s.num = RDRAM_RSVD;  s.rd = 5'd9;  s.addr = 32'h0000_1003;
    drive(s, 1);
    sb.push_back(mk_exp(0, 6'h00, 0, '0, 0, 1, 5'd9, 32'hCAFE_F00D, s.pc));
    #1;
    `SB_CHECK("ld_reserved_as_word")

    drive(idle(), 0);
    check_retired("load_retired");
  endtask

  task automatic test_exceptions();
    stim_t s;
    s = idle();
    s.valid = 1'b1;  s.pc = 32'h1C00_0100;  s.rf_we = 1'b1;  s.rd = 5'd3;
    s.alu = 32'h0000_0055;  s.addr = 32'h0000_2002;
    s.irq = 1'b1;  s.ale = 1'b1;
    drive(s, 0);
    sb.push_back(mk_exp(1, 6'h00, 0, '0, 1, 0, 5'd3, 32'h55, s.pc));
    #1;
    `SB_CHECK("int_over_ale")

    s.irq = 1'b0;
    drive(s, 0);
    sb.push_back(mk_exp(1, 6'h09, 1, 32'h0000_2002, 1, 0, 5'd3, 32'h55, s.pc));
    #1;
    `SB_CHECK("ale_alone")

    s.ale = 1'b0;  s.adef = 1'b1;  s.pc = 32'h1C00_0101;  s.ine = 1'b1;
    drive(s, 0);
    sb.push_back(mk_exp(1, 6'h08, 1, 32'h1C00_0101, 1, 0, 5'd3, 32'h55, s.pc));
    #1;
    `SB_CHECK("adef_over_ine")

    s.adef = 1'b0;  s.sys = 1'b1;  s.brk = 1'b1;  s.ale = 1'b1;
    drive(s, 0);
    sb.push_back(mk_exp(1, 6'h0D, 0, '0, 1, 0, 5'd3, 32'h55, s.pc));
    #1;
    `SB_CHECK("ine_over_sys_brk_ale")

    s.ine = 1'b0;
    drive(s, 0);
    sb.push_back(mk_exp(1, 6'h0B, 0, '0, 1, 0, 5'd3, 32'h55, s.pc));
    #1;
    `SB_CHECK("sys_over_brk_ale")

    s.sys = 1'b0;
    drive(s, 0);
    sb.push_back(mk_exp(1, 6'h0C, 0, '0, 1, 0, 5'd3, 32'h55, s.pc));
    #1;
    `SB_CHECK("brk_over_ale")

    drive(idle(), 0);
    check_retired("exc_retired_unchanged");

    s = idle();
    s.valid = 1'b1;  s.pc = 32'h1C00_0200;  s.ertn = 1'b1;
    drive(s, 1);
    sb.push_back(mk_exp(0, 6'h00, 0, '0, 1, 0, 5'd0, 32'h0, s.pc));
    #1;
    `SB_CHECK("ertn_alone")

    s.sys = 1'b1;
    drive(s, 0);
    sb.push_back(mk_exp(1, 6'h0B, 0, '0, 1, 0, 5'd0, 32'h0, s.pc));
    #1;
    `SB_CHECK("ertn_with_sys")

    drive(idle(), 0);
    check_retired("ertn_retired");
  endtask

  task automatic test_result_select();
    stim_t s;
    s = idle();
    s.valid = 1'b1;  s.pc = 32'h1C00_0300;  s.rf_we = 1'b1;  s.rd = 5'd2;
    s.rj = 5'd7;  s.is_rj = 1'b1;  s.from_cnt = 1'b1;  s.res_of_cnt = 32'h1234;
    s.alu = 32'h0000_0999;  s.csr = 32'h0000_ABCD;
    drive(s, 1);
    sb.push_back(mk_exp(0, 6'h00, 0, '0, 0, 1, 5'd7, 32'h1234, s.pc));
    #1;
    `SB_CHECK("rdcntid")

    s.is_rj = 1'b0;  s.from_csr = 1'b1;
    drive(s, 1);
    sb.push_back(mk_exp(0, 6'h00, 0, '0, 0, 1, 5'd2, 32'hABCD, s.pc));
    #1;
    `SB_CHECK("csr_over_cnt")

    s.from_dram = 1'b1;  s.rdata = 32'h1122_3344;  s.num = RDRAM_WORD;
    drive(s, 1);
    sb.push_back(mk_exp(0, 6'h00, 0, '0, 0, 1, 5'd2, 32'h1122_3344, s.pc));
    #1;
    `SB_CHECK("dram_over_csr")

    s.from_dram = 1'b0;  s.from_csr = 1'b0;  s.from_cnt = 1'b0;
    drive(s, 1);
    sb.push_back(mk_exp(0, 6'h00, 0, '0, 0, 1, 5'd2, 32'h999, s.pc));
    #1;
    `SB_CHECK("alu_default")

    drive(idle(), 0);
    check_retired("select_retired");
  endtask

  task automatic test_back_to_back();
    stim_t s;
    for (int i = 0; i < 6; i++) begin
      s = idle();
      s.valid = 1'b1;  s.pc = 32'h1C00_1000 + 32'(4 * i);  s.rf_we = 1'b1;
      s.rd = 5'(i + 10);  s.alu = $urandom;
      s.brk = (i == 3);
      drive(s, (i != 3));
      if (i == 3) sb.push_back(mk_exp(1, 6'h0C, 0, '0, 1, 0, s.rd, s.alu, s.pc));
      else        sb.push_back(mk_exp(0, 6'h00, 0, '0, 0, 1, s.rd, s.alu, s.pc));
      #1;
      `SB_CHECK("back_to_back")
    end
    drive(idle(), 0);
    check_retired("b2b_retired");
  endtask

  task automatic test_invalid();
    stim_t s;
    s = '{valid: 1'b0, pc: 32'h1C00_0400, rf_we: 1'b1, rd: 5'd4, rj: 5'd6,
          alu: 32'h1, from_dram: 1'b1, rdata: 32'hFFFF_FFFF, addr: 32'h3,
          num: 2'b01, sext: 1'b1, zext: 1'b1, from_csr: 1'b1, csr: 32'h2,
          from_cnt: 1'b1, res_of_cnt: 32'h3, is_rj: 1'b1, irq: 1'b1,
          adef: 1'b1, ine: 1'b1, sys: 1'b1, brk: 1'b1, ale: 1'b1, ertn: 1'b1};
    drive(s, 0);
    sb.push_back(mk_exp(0, 6'h00, 0, '0, 0, 0, 5'd0, '0, '0));
    #1;
    `SB_CHECK("invalid_all_zero")
    drive(idle(), 0);
    check_retired("invalid_retired");
  endtask

  task automatic test_mid_reset();
    stim_t s;
    s = idle();
    s.valid = 1'b1;  s.pc = 32'h1C00_0500;  s.rf_we = 1'b1;  s.rd = 5'd8;
    s.alu = 32'h0000_7777;
    drive(s, 0);
    rst = 1'b1;
    sb.push_back(mk_exp(0, 6'h00, 0, '0, 0, 1, 5'd8, 32'h7777, s.pc));
    #1;
    `SB_CHECK("comb_during_reset")
    @(negedge clk);
    rst = 1'b0;
    apply(idle());
    exp_ret = '0;
    pend = 1'b0;
    n_chk++;
    if (cnt_value !== 64'd0) begin
      n_fail++;
      $display("FAIL mid_reset_cnt: got %h expected %h", cnt_value, 64'd0);
    end
    check_retired("mid_reset_retired");
    @(negedge clk);
    n_chk++;
    if (cnt_value !== 64'd1) begin
      n_fail++;
      $display("FAIL post_reset_cnt: got %h expected %h", cnt_value, 64'd1);
    end
  endtask

  task automatic test_wrap();
    stim_t s;
    @(negedge clk);
    force dut.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.cnt_q;
    @(negedge clk);
    n_chk++;
    if (cnt_value !== 64'd0) begin
      n_fail++;
      $display("FAIL cnt_wrap: got %h expected %h", cnt_value, 64'd0);
    end

    @(negedge clk);
    force dut.ret_q = 32'hFFFF_FFFF;
    #1;
    release dut.ret_q;
    exp_ret = 32'hFFFF_FFFF;
    pend = 1'b0;
    s = idle();
    s.valid = 1'b1;  s.pc = 32'h1C00_0600;  s.rf_we = 1'b1;  s.rd = 5'd1;
    s.alu = 32'h42;
    drive(s, 1);
    sb.push_back(mk_exp(0, 6'h00, 0, '0, 0, 1, 5'd1, 32'h42, s.pc));
    #1;
    `SB_CHECK("wrap_commit")
    drive(idle(), 0);
    n_chk++;
    if (retired !== 32'h0) begin
      n_fail++;
      $display("FAIL retired_wrap: got %h expected %h", retired, 32'h0);
    end
  endtask

  initial begin
    rst  = 1'b1;
    pend = 1'b0;
    exp_ret = '0;
    apply(idle());
    test_reset();
    test_load();
    test_exceptions();
    test_result_select();
    test_back_to_back();
    test_invalid();
    test_mid_reset();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
